// File: rtl/matmul_operand_sequencer.sv
// Operand sequencer for an N-wide byte dot-product stage: loads A and B from a byte
// stream, issues row/column pairs one at a time and returns each result with its indices.
module matmul_operand_sequencer #(
  parameter int ROW_SIZE = 3,
  parameter int IDX_W    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ROW_SIZE-1:0][7:0] op_row,
  output logic [ROW_SIZE-1:0][7:0] op_col,
  output logic                     op_valid,
  input  logic                     dot_valid,
  input  logic [7:0]               dot_data,
  output logic [7:0]               res_data,
  output logic [IDX_W-1:0]         res_row,
  output logic [IDX_W-1:0]         res_col,
  output logic                     res_last,
  output logic                     res_valid,
  input  logic                     res_ready
);
  localparam int NN    = ROW_SIZE * ROW_SIZE;
  localparam int TOTAL = 2 * NN;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROW_SIZE - 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]           r_i, r_j, w_i_nxt, w_j_nxt;
  logic                       r_op_valid, w_op_valid_nxt;
  logic                       r_res_valid, w_res_valid_nxt;
  logic                       r_res_last, w_res_last_nxt;
  logic [7:0]                 r_res_data;
  logic [IDX_W-1:0]           r_res_row, r_res_col;
  logic [ROW_SIZE-1:0][7:0]   r_op_row, r_op_col, w_op_row, w_op_col;
  logic                       w_capture, w_load_op, w_accept;
  logic [7:0]                 r_mat_a [NN];
  logic [7:0]                 r_mat_b [NN];
  logic [7:0]                 w_mat_a [NN];
  logic [7:0]                 w_mat_b [NN];

  assign in_ready  = (r_state == S_LOAD);
  assign w_accept  = in_valid && (r_state == S_LOAD);
  assign op_row    = r_op_row;
  assign op_col    = r_op_col;
  assign op_valid  = r_op_valid;
  assign res_data  = r_res_data;
  assign res_row   = r_res_row;
  assign res_col   = r_res_col;
  assign res_last  = r_res_last;
  assign res_valid = r_res_valid;

  // Operands are selected from the post-write matrix view so the final loaded byte
  // is already visible when (0,0) is latched on the same edge.
  always_comb begin
    w_mat_a  = r_mat_a;
    w_mat_b  = r_mat_b;
    w_op_row = '0;
    w_op_col = '0;
    for (int k = 0; k < NN; k++) begin
      if (w_accept && int'(r_cnt) == k)      w_mat_a[k] = in_data;
      if (w_accept && int'(r_cnt) == k + NN) w_mat_b[k] = in_data;
    end
    for (int r = 0; r < ROW_SIZE; r++) begin
      for (int k = 0; k < ROW_SIZE; k++) begin
        if (int'(w_i_nxt) == r) w_op_row[k] = w_mat_a[r*ROW_SIZE + k];
        if (int'(w_j_nxt) == r) w_op_col[k] = w_mat_b[k*ROW_SIZE + r];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_mat_a <= w_mat_a;
    r_mat_b <= w_mat_b;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_i_nxt         = r_i;
    w_j_nxt         = r_j;
    w_op_valid_nxt  = 1'b0;
    w_res_valid_nxt = r_res_valid;
    w_res_last_nxt  = r_res_last;
    w_capture       = 1'b0;
    w_load_op       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (in_valid) begin
          if (r_cnt == CNT_W'(TOTAL - 1)) begin
            w_i_nxt        = '0;
            w_j_nxt        = '0;
            w_load_op      = 1'b1;
            w_op_valid_nxt = 1'b1;
            w_state_nxt    = S_ISSUE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (dot_valid) begin
          w_capture       = 1'b1;
          w_res_valid_nxt = 1'b1;
          w_res_last_nxt  = (r_i == LAST) && (r_j == LAST);
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          if (r_res_last) begin
            w_res_last_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_LOAD;
          end else begin
            if (r_j == LAST) begin
              w_j_nxt = '0;
              w_i_nxt = r_i + IDX_W'(1);
            end else begin
              w_j_nxt = r_j + IDX_W'(1);
            end
            w_load_op      = 1'b1;
            w_op_valid_nxt = 1'b1;
            w_state_nxt    = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_op_valid  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_data  <= '0;
      r_res_row   <= '0;
      r_res_col   <= '0;
      r_op_row    <= '0;
      r_op_col    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_i         <= w_i_nxt;
      r_j         <= w_j_nxt;
      r_op_valid  <= w_op_valid_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_last  <= w_res_last_nxt;
      if (w_capture) begin
        r_res_data <= dot_data;
        r_res_row  <= r_i;
        r_res_col  <= r_j;
      end
      if (w_load_op) begin
        r_op_row <= w_op_row;
        r_op_col <= w_op_col;
      end
    end
  end
endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Bench for matmul_operand_sequencer: a 3-cycle dot-product model downstream, a result
// scoreboard filled from the loaded matrices, and a ROW_SIZE=1 instance.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_matmul_operand_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [7:0]      in_data;
  logic            in_valid, in_ready;
  logic [2:0][7:0] op_row, op_col;
  logic            op_valid, dot_valid;
  logic [7:0]      dot_data, res_data;
  logic [1:0]      res_row, res_col;
  logic            res_last, res_valid, res_ready;

  logic [7:0]      in_data1;
  logic            in_valid1, in_ready1;
  logic [0:0][7:0] op_row1, op_col1;
  logic            op_valid1, dot_valid1;
  logic [7:0]      dot_data1, res_data1;
  logic [0:0]      res_row1, res_col1;
  logic            res_last1, res_valid1, res_ready1;

  matmul_operand_sequencer #(.ROW_SIZE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_row(op_row), .op_col(op_col), .op_valid(op_valid), .dot_valid(dot_valid),
    .dot_data(dot_data), .res_data(res_data), .res_row(res_row), .res_col(res_col),
    .res_last(res_last), .res_valid(res_valid), .res_ready(res_ready));

  matmul_operand_sequencer #(.ROW_SIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_row(op_row1), .op_col(op_col1), .op_valid(op_valid1), .dot_valid(dot_valid1),
    .dot_data(dot_data1), .res_data(res_data1), .res_row(res_row1), .res_col(res_col1),
    .res_last(res_last1), .res_valid(res_valid1), .res_ready(res_ready1));

  int checks = 0, failures = 0;

  // Dot-product stage model: 3-cycle latency, 8-bit wrapping sum
  function automatic logic [7:0] dot3(input logic [2:0][7:0] r, input logic [2:0][7:0] c);
    logic [7:0] s = 8'h00;
    for (int k = 0; k < 3; k++) s = s + r[k] * c[k];
    return s;
  endfunction

  logic [2:0] dv_sr = '0, dv1_sr = '0;
  logic [7:0] dd_sr [3];
  logic [7:0] dd1_sr [3];
  logic       spur_dv = 1'b0;
  always @(posedge clk) begin
    dv_sr     <= {dv_sr[1:0], op_valid};
    dd_sr[0]  <= dot3(op_row, op_col);
    dd_sr[1]  <= dd_sr[0];
    dd_sr[2]  <= dd_sr[1];
    dv1_sr    <= {dv1_sr[1:0], op_valid1};
    dd1_sr[0] <= op_row1[0] * op_col1[0];
    dd1_sr[1] <= dd1_sr[0];
    dd1_sr[2] <= dd1_sr[1];
  end
  assign dot_valid  = dv_sr[2] | spur_dv;
  assign dot_data   = spur_dv ? 8'h5A : dd_sr[2];
  assign dot_valid1 = dv1_sr[2];
  assign dot_data1  = dd1_sr[2];

  typedef struct packed {logic [7:0] d; logic [1:0] r; logic [1:0] c; logic l;} exp_t;
  exp_t q[$];
  int got = 0, op_cnt = 0, acc_cnt = 0, cyc = 0, acc_cyc = 0, op_cyc = 0;
  bit first_pend = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;
  logic [1:0] prw = '0, pcl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        acc_cyc = cyc;
        first_pend = 1'b1;
      end
      if (op_valid) begin
        op_cnt++;
        op_cyc = cyc;
        `CHK("op_during_res", res_valid, 1'b0)
        if (first_pend) begin
          `CHK("issue_latency", cyc, acc_cyc + 1)
          first_pend = 1'b0;
        end
      end
      if (res_valid && !pv) `CHK("res_latency", cyc, op_cyc + 4)
      if (pv && !pr)
        `CHK("hold_stable", {res_valid, res_data, res_row, res_col, res_last}, {1'b1, pd, prw, pcl, pl})
      if (res_valid && res_ready) begin
        checks++;
        assert (q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_result observed=%0h expected=none", res_data);
        end
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          `CHK("res_data", res_data, e.d)
          `CHK("res_idx_last", {res_row, res_col, res_last}, {e.r, e.c, e.l})
        end
        got++;
      end
      pv <= res_valid; pr <= res_ready; pd <= res_data;
      prw <= res_row; pcl <= res_col; pl <= res_last;
    end else begin
      pv <= 1'b0;
    end
  end

  logic [7:0] ma [9];
  logic [7:0] mb [9];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load3(input bit gaps, input bit spur);
    logic [7:0] s;
    exp_t e;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 8'h00;
        for (int k = 0; k < 3; k++) s = s + ma[i*3+k] * mb[k*3+j];
        e.d = s; e.r = 2'(i); e.c = 2'(j); e.l = (i == 2 && j == 2);
        q.push_back(e);
      end
    for (int n = 0; n < 18; n++) begin
      if (n < 9) in_data = ma[n];
      else       in_data = mb[n-9];
      in_valid = 1'b1;
      tick();
      if (gaps) begin
        in_valid = 1'b0;
        spur_dv  = spur && (n == 5);
        tick();
        spur_dv  = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int target, input int budget);
    while (got < target && budget > 0) begin tick(); budget--; end
    checks++;
    assert (got >= target) else begin
      failures++;
      $error("FAIL result_timeout observed=%0d expected=%0d", got, target);
    end
  endtask

  task automatic end_run(input int op0, input int acc0);
    `CHK("op_pulses", op_cnt - op0, 9)
    `CHK("bytes_consumed", acc_cnt - acc0, 18)
    `CHK("in_ready_after_last", in_ready, 1'b1)
    `CHK("res_last_cleared", res_last, 1'b0)
    `CHK("res_valid_cleared", res_valid, 1'b0)
  endtask

  task automatic rand_mats();
    for (int n = 0; n < 9; n++) begin
      ma[n] = 8'($urandom);
      mb[n] = 8'($urandom);
    end
  endtask

  initial begin
    int base, op0, acc0, budget;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; res_ready1 = 1'b1;
    repeat (2) tick();
    `CHK("rst_flags", {op_valid, res_valid, res_last}, 3'b000)
    `CHK("rst_res", {res_data, res_row, res_col}, 12'h000)
    `CHK("rst_ops", {op_row, op_col}, 48'h0)
    rst_n = 1'b1;
    tick();
    `CHK("in_ready_idle", in_ready, 1'b1)
    `CHK("op_valid_idle", op_valid, 1'b0)

    // Run 1: A all ones, B = 1..9
    for (int n = 0; n < 9; n++) begin ma[n] = 8'd1; mb[n] = 8'(n + 1); end
    base = got; op0 = op_cnt; acc0 = acc_cnt;
    load3(1'b0, 1'b0);
    wait_got(base + 9, 200);
    end_run(op0, acc0);

    // Run 2: in_valid toggling, spurious dot_valid during load
    rand_mats();
    base = got; op0 = op_cnt; acc0 = acc_cnt;
    load3(1'b1, 1'b1);
    wait_got(base + 9, 200);
    end_run(op0, acc0);

    // Run 3: stall on (1,1), spurious dot_valid in HOLD, 0xAA offered during compute
    rand_mats();
    base = got; op0 = op_cnt; acc0 = acc_cnt;
    load3(1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'hAA;
    `CHK("in_ready_compute", in_ready, 1'b0)
    budget = 200;
    while (!(res_valid && res_row == 2'd1 && res_col == 2'd1) && budget > 0) begin tick(); budget--; end
    `CHK("stall_target_seen", {res_valid, res_row, res_col}, 5'b1_01_01)
    res_ready = 1'b0;
    repeat (2) tick();
    spur_dv = 1'b1;
    tick();
    spur_dv = 1'b0;
    repeat (3) tick();
    `CHK("stall_idx", {res_valid, res_row, res_col}, 5'b1_01_01)
    `CHK("in_ready_hold", in_ready, 1'b0)
    res_ready = 1'b1;
    wait_got(base + 9, 200);
    in_valid = 1'b0;
    end_run(op0, acc0);

    // Run 4: asynchronous reset mid-WAIT, then a fresh load
    rand_mats();
    load3(1'b0, 1'b0);
    budget = 50;
    while (!op_valid && budget > 0) begin tick(); budget--; end
    `CHK("issue_before_reset", op_valid, 1'b1)
    tick();
    #2 rst_n = 1'b0;
    #1;
    `CHK("reset_async_flags", {op_valid, res_valid, res_last}, 3'b000)
    `CHK("reset_in_ready", in_ready, 1'b1)
    tick();
    rst_n = 1'b1;
    q.delete();
    base = got;
    repeat (6) tick();
    `CHK("late_dot_ignored", {res_valid, 1'b0}, 2'b00)
    `CHK("no_result_after_reset", got - base, 0)
    rand_mats();
    op0 = op_cnt; acc0 = acc_cnt;
    load3(1'b1, 1'b0);
    wait_got(base + 9, 300);
    end_run(op0, acc0);

    // Run 5: ROW_SIZE = 1
    in_data1 = 8'd5; in_valid1 = 1'b1;
    tick();
    in_data1 = 8'd7;
    tick();
    in_valid1 = 1'b0;
    budget = 50;
    while (!res_valid1 && budget > 0) begin tick(); budget--; end
    `CHK("n1_res_valid", res_valid1, 1'b1)
    `CHK("n1_res_data", res_data1, 8'd35)
    `CHK("n1_idx_last", {res_row1, res_col1, res_last1}, 3'b001)
    tick();
    `CHK("n1_done", {res_valid1, res_last1, in_ready1}, 3'b001)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matmul_operand_sequencer.md
Name: matmul_operand_sequencer

Overview:
- Upstream feeder for the team's ROW_SIZE-wide 8-bit dot-product stage.
- Loads two ROW_SIZE x ROW_SIZE byte matrices A and B from a serial byte stream.
- Walks every (i,j) pair: presents row i of A and column j of B with a one-cycle issue pulse, waits for that stage's dot-product result, then emits the result with its indices on a ready/valid output.
- Together with the dot-product stage it forms a complete C = A x B engine.

Parameters:
- ROW_SIZE, 3: matrix dimension N; operand vectors carry N bytes. Legal values are 1..8.
- IDX_W, max(1,$clog2(ROW_SIZE)): width of the row/column index outputs.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset. Assertion takes effect immediately; release is synchronous to clk.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte on this cycle.
- op_row  out  [ROW_SIZE-1:0][7:0]  element k = A[i][k].
- op_col  out  [ROW_SIZE-1:0][7:0]  element k = B[k][j].
- op_valid  out  1  one-cycle issue pulse to the dot-product stage.
- dot_valid  in  1  result strobe from the dot-product stage.
- dot_data  in  8  dot-product result.
- res_data  out  8  result C[i][j].
- res_row  out  IDX_W  index i of the current result.
- res_col  out  IDX_W  index j of the current result.
- res_last  out  1  result is C[N-1][N-1].
- res_valid  out  1  result is held and valid.
- res_ready  in  1  consumer accepts the result.

Behaviour:
- Reset values:
  - state = LOAD; all counters, i and j = 0.
  - op_valid, res_valid, res_last = 0.
  - res_data, res_row, res_col, op_row, op_col = 0.
  - in_ready = 1 once reset is released.
  - Matrix storage is not reset.
- States: LOAD, ISSUE, WAIT, HOLD. All outputs are registered except in_ready, which is (state==LOAD).
- LOAD:
  - A byte is accepted when in_valid && in_ready.
  - Load counter runs 0..2N*N-1. The first N*N bytes fill A row-major; the next N*N bytes fill B row-major.
  - Gaps in in_valid are tolerated.
  - On acceptance of byte 2N*N-1: i=j=0, op_row/op_col are loaded for (0,0), go to ISSUE.
- ISSUE:
  - op_valid = 1 for exactly this cycle, then go to WAIT.
  - op_row/op_col are stable from ISSUE until the next advance.
- WAIT:
  - op_valid = 0.
  - On dot_valid: res_data <= dot_data, res_row <= i, res_col <= j, res_last <= (i==N-1 && j==N-1), res_valid <= 1, go to HOLD.
  - No timeout.
- HOLD:
  - res_* are held stable while res_valid && !res_ready.
  - On handshake: res_valid <= 0.
  - If res_last: clear res_last and the load counter, go to LOAD.
  - Otherwise: advance j; on j==N-1, wrap j to 0 and increment i. Reload op_row/op_col and go to ISSUE.
  - The next op_valid therefore occurs no earlier than 1 cycle after the handshake. This guarantees the dot-product stage is idle before each issue.
- dot_valid outside WAIT is ignored. At most one result is captured per issue.
- in_valid outside LOAD: in_ready = 0 and the byte is not consumed.
- Arithmetic: dot_data is passed through unmodified. The 8-bit wrap is the dot-product stage's behaviour.
- Latency: with the 3-cycle dot-product stage, res_valid rises 4 cycles after the op_valid cycle.
- Throughput: one result per 5 cycles with res_ready tied high.
- Reset mid-operation (any state): all of the above reset values apply at once, including op_valid and res_valid dropping to 0. A full reload of 2N*N bytes is required afterwards.

Test Plan:
1. N=3, A = all 1s, B = 1..9 row-major, res_ready=1, real dot-product stage downstream -> 9 results in order (0,0)..(2,2): 12,15,18,12,15,18,12,15,18; res_last only on the 9th; in_ready returns to 1 on the cycle after the final handshake.
2. Load with in_valid toggling every other cycle -> exactly 18 bytes consumed; op_valid first asserts the cycle after byte 18 is accepted; res_valid rises 4 cycles after op_valid.
3. res_ready low for 6 cycles on result (1,1) -> res_data, res_row=1, res_col=1 held; no op_valid while HOLD persists; exactly 9 op_valid pulses total.
4. in_valid=1 with data 0xAA throughout compute -> in_ready=0 and results are unaffected. Spurious dot_valid injected during LOAD and HOLD -> ignored, no extra results.
5. rst_n asserted mid-WAIT (asynchronous, off-edge) -> op_valid, res_valid and res_last go to 0 immediately; after release in_ready=1; a subsequent late dot_valid is ignored; a fresh load runs correctly.
6. ROW_SIZE=1, A=5, B=7 -> single result 35 with res_row=0, res_col=0, res_last=1.
